decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Consumer end of the fetch→decode interface. Takes the 64-bit two-instruction bundle and its bundle PC from fetch.
- Detects scoreboard and intra-bundle hazards, splits or holds bundles, and drives the combinational interlock back to fetch.
- Issues up to two instructions per cycle through one register stage to exec.
- Tracks outstanding long-latency destinations in a 32-entry scoreboard cleared by two writeback ports.

Parameters:
NREG, 32, architectural register count (scoreboard depth; index width 5)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
pc_in  in  32  bundle PC from fetch (pc_to_the_next)
bundle_in  in  64  [63:32]=slot0 (older), [31:0]=slot1, from fetch (inst_to_the_next)
exec_stall  in  1  exec cannot accept a new bundle this cycle
flush  in  1  branch resolved taken; same-cycle copy of fetch's branch_flag
wb0_valid  in  1  writeback port 0 retires a long-latency result
wb0_rd  in  5  destination of wb0
wb1_valid  in  1  writeback port 1 retires a long-latency result
wb1_rd  in  5  destination of wb1
interlock  out  1  combinational; fetch holds its bundle and re-reads it
issue_pc  out  32  PC of issued bundle
slot0_inst  out  32  issued slot0 instruction
slot0_valid  out  1  slot0 carries a real instruction
slot1_inst  out  32  issued slot1 instruction
slot1_valid  out  1  slot1 carries a real instruction

Behaviour:
- Fields: opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11].
- A slot is live when its opcode is not Nop. Liveness comes only from the opcode; no PC-based checks.
- Bubble: both valid=0, both insts={Nop,26'b0}, issue_pc holds its previous value.
- Reset: all outputs bubble, issue_pc=0, scoreboard all 0, state=FULL. interlock=0 while rstn=0.
- Scoreboard:
  - sb[r]=1 means r has an outstanding long-latency write.
  - r0 is never set.
  - Effective pending = sb[r] & ~(wb0_valid & wb0_rd==r) & ~(wb1_valid & wb1_rd==r). Same-cycle writeback is bypassed.
  - On issue of a live slot with is_long_latency(opcode) and rd≠0, set sb[rd]. Set wins over a same-cycle clear of the same rd.
- Per-slot hazard:
  - sb_haz: live, and any used source (uses_rs1/uses_rs2) or written rd (writes_rd) is effectively pending.
  - Register 0 never causes a hazard.
- Pair hazard (both slots live):
  - slot1 reads or writes slot0's rd (rd≠0, slot0 writes_rd), or
  - both slots is_mem (single memory port), or
  - both slots is_branch.
- States:
  - FULL: both slots of the current bundle still to issue.
  - SECOND: slot0 already issued, slot1 pending.
- Per-cycle priority (first match wins):
  1. flush: outputs→bubble, state→FULL, interlock=0. Scoreboard is not cleared. Writebacks still apply; no sets.
  2. exec_stall: outputs hold, scoreboard sets suppressed, interlock=1, state unchanged.
  3. FULL & (sb_haz slot0, or sb_haz slot1 without pair hazard): outputs→bubble, interlock=1.
  4. FULL & pair hazard:
     - Issue slot0 only: slot1_valid=0, slot1_inst=Nop.
     - interlock=1, state→SECOND.
  5. SECOND & sb_haz slot1: bubble, interlock=1.
  6. SECOND:
     - Issue slot1 alone: in slot1 position, slot0_valid=0.
     - interlock=0, state→FULL.
  7. FULL otherwise: issue both live slots, interlock=0.
- Timing:
  - Issue latency is 1 cycle: bundle present at cycle t appears on outputs at t+1.
  - interlock depends only on current inputs, state, and scoreboard. It must settle within the cycle, because fetch muxes its BRAM address on it.
- An all-Nop bundle issues as a bubble with interlock=0. Fetch's post-reset and post-branch Nop bundles pass through without stalling.

Decomposition:
- inst_package gains:
  - field-position localparams;
  - functions is_long_latency, is_mem, is_branch, uses_rs1, uses_rs2, writes_rd over opcode_t;
  - typedef decode_state_t {FULL, SECOND}.
- Nop is already defined there.
- One sub-module, reg_scoreboard: set port, two clear ports, 32-bit pending vector with bypass.
- Hazard and issue logic stay in decode_issue.

Test Plan:
- Reset, then bundle {add r3,r1,r2 | sub r4,r5,r6} at pc 0x10 → t+1: both valid, issue_pc=0x10, interlock stays 0.
- Bundle {add r3,r1,r2 | add r7,r3,r3} → interlock=1 one cycle, slot0 only issued. Next cycle slot1 only, interlock=0. Total 2 cycles.
- Issue load r8; next bundle reads r8 → interlock held and bubbles until wb0_valid with wb0_rd=8. In that same cycle the reader issues (bypass), interlock drops.
- Split in progress (SECOND) plus flush=1 → next outputs bubble, state FULL. sb[8] from an earlier load remains set until its writeback.
- exec_stall held 3 cycles with a valid bundle → outputs constant, interlock=1 throughout. A long-latency rd is not set until the issue cycle.
- Simultaneous wb0_rd=5 clear and issue of load r5 → sb[5]=1 afterwards. wb0_rd=0 or wb1_rd=0 with valid → no effect.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: instruction fields, opcode classes and decode FSM state
package decode_issue_pkg;
  localparam int NREG = 32;
  localparam int RW = $clog2(NREG);
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RD_HI = 25;
  localparam int RD_LO = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  typedef enum logic [5:0] {
    Nop   = 6'd0,
    Add   = 6'd1,
    Sub   = 6'd2,
    Load  = 6'd3,
    Store = 6'd4,
    Mul   = 6'd5,
    Beq   = 6'd6,
    Jmp   = 6'd7
  } opcode_t;
  localparam logic [31:0] NOP_INST = {Nop, 26'b0};
  typedef enum logic {FULL, SECOND} decode_state_t;
  function automatic logic is_long_latency(opcode_t op);
    return op inside {Load, Mul};
  endfunction
  function automatic logic is_mem(opcode_t op);
    return op inside {Load, Store};
  endfunction
  function automatic logic is_branch(opcode_t op);
    return op inside {Beq, Jmp};
  endfunction
  function automatic logic uses_rs1(opcode_t op);
    return op inside {Add, Sub, Load, Store, Mul, Beq};
  endfunction
  function automatic logic uses_rs2(opcode_t op);
    return op inside {Add, Sub, Store, Mul, Beq};
  endfunction
  function automatic logic writes_rd(opcode_t op);
    return op inside {Add, Sub, Load, Mul};
  endfunction
endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch-to-decode bundle path with the interlock back to fetch
interface decode_issue_if;
  logic [31:0] pc_in;
  logic [63:0] bundle_in;
  logic        interlock;
  modport master(output pc_in, bundle_in, input interlock);
  modport slave(input pc_in, bundle_in, output interlock);
endinterface

// File: rtl/decode_issue_reg_scoreboard.sv
// reg_scoreboard: outstanding long-latency destinations with same-cycle writeback bypass
module reg_scoreboard
  import decode_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREG-1:0] i_set,
  input  logic            i_clr0_valid,
  input  logic [RW-1:0]   i_clr0_rd,
  input  logic            i_clr1_valid,
  input  logic [RW-1:0]   i_clr1_rd,
  output logic [NREG-1:0] o_pending
);
  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_clr;
  assign w_clr = ({NREG{i_clr0_valid}} & (NREG'(1) << i_clr0_rd)) |
                 ({NREG{i_clr1_valid}} & (NREG'(1) << i_clr1_rd));
  assign o_pending = r_sb & ~w_clr;
  // clears apply first so a same-cycle set of the same register wins; r0 never pends
  always_ff @(posedge clk) begin
    if (!rstn) r_sb <= '0;
    else r_sb <= (o_pending | i_set) & ~NREG'(1);
  end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: hazard-checked dual issue from the fetch bundle into one register stage
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  decode_issue_if.slave i_fetch,
  input  logic          i_exec_stall,
  input  logic          i_flush,
  input  logic          i_wb0_valid,
  input  logic [RW-1:0] i_wb0_rd,
  input  logic          i_wb1_valid,
  input  logic [RW-1:0] i_wb1_rd,
  output logic [31:0]   o_issue_pc,
  output logic [31:0]   o_slot0_inst,
  output logic          o_slot0_valid,
  output logic [31:0]   o_slot1_inst,
  output logic          o_slot1_valid
);
  function automatic logic pend(logic [RW-1:0] r, logic [NREG-1:0] p);
    return r != '0 && p[r];
  endfunction
  function automatic logic sb_haz(opcode_t op, logic [RW-1:0] rd, logic [RW-1:0] rs1,
                                  logic [RW-1:0] rs2, logic [NREG-1:0] p);
    return op != Nop && ((uses_rs1(op) && pend(rs1, p)) || (uses_rs2(op) && pend(rs2, p)) ||
                         (writes_rd(op) && pend(rd, p)));
  endfunction
  function automatic logic [NREG-1:0] set_mask(opcode_t op, logic [RW-1:0] rd);
    return (op != Nop && is_long_latency(op) && rd != '0) ? NREG'(1) << rd : '0;
  endfunction
  logic [31:0]     w_i0, w_i1;
  opcode_t         w_op0, w_op1;
  logic [RW-1:0]   w_rd0, w_rs10, w_rs20, w_rd1, w_rs11, w_rs21;
  logic [NREG-1:0] w_pending, w_set;
  logic            w_live0, w_live1, w_haz0, w_haz1, w_dep, w_pair, w_interlock;
  decode_state_t   r_state, w_nxt_state;
  logic [31:0]     r_pc, r_i0, r_i1, w_nxt_pc, w_nxt_i0, w_nxt_i1;
  logic            r_v0, r_v1, w_nxt_v0, w_nxt_v1;
  assign w_i0 = i_fetch.bundle_in[63:32];
  assign w_i1 = i_fetch.bundle_in[31:0];
  assign w_op0 = opcode_t'(w_i0[OP_HI:OP_LO]);
  assign w_op1 = opcode_t'(w_i1[OP_HI:OP_LO]);
  assign w_rd0 = w_i0[RD_HI:RD_LO];
  assign w_rs10 = w_i0[RS1_HI:RS1_LO];
  assign w_rs20 = w_i0[RS2_HI:RS2_LO];
  assign w_rd1 = w_i1[RD_HI:RD_LO];
  assign w_rs11 = w_i1[RS1_HI:RS1_LO];
  assign w_rs21 = w_i1[RS2_HI:RS2_LO];
  assign w_live0 = w_op0 != Nop;
  assign w_live1 = w_op1 != Nop;
  assign w_haz0 = sb_haz(w_op0, w_rd0, w_rs10, w_rs20, w_pending);
  assign w_haz1 = sb_haz(w_op1, w_rd1, w_rs11, w_rs21, w_pending);
  assign w_dep = writes_rd(w_op0) && w_rd0 != '0 &&
                 ((uses_rs1(w_op1) && w_rs11 == w_rd0) || (uses_rs2(w_op1) && w_rs21 == w_rd0) ||
                  (writes_rd(w_op1) && w_rd1 == w_rd0));
  assign w_pair = w_live0 && w_live1 &&
                  (w_dep || (is_mem(w_op0) && is_mem(w_op1)) || (is_branch(w_op0) && is_branch(w_op1)));
  reg_scoreboard u_sb (
    .clk          (clk),
    .rstn         (rstn),
    .i_set        (w_set),
    .i_clr0_valid (i_wb0_valid),
    .i_clr0_rd    (i_wb0_rd),
    .i_clr1_valid (i_wb1_valid),
    .i_clr1_rd    (i_wb1_rd),
    .o_pending    (w_pending)
  );
  // prioritised issue decision: flush, stall, hazard bubble, split, or full issue
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc = r_pc;
    w_nxt_i0 = NOP_INST;
    w_nxt_v0 = 1'b0;
    w_nxt_i1 = NOP_INST;
    w_nxt_v1 = 1'b0;
    w_set = '0;
    w_interlock = 1'b0;
    if (i_flush) begin
      w_nxt_state = FULL;
    end else if (i_exec_stall) begin
      w_nxt_i0 = r_i0;
      w_nxt_v0 = r_v0;
      w_nxt_i1 = r_i1;
      w_nxt_v1 = r_v1;
      w_interlock = 1'b1;
    end else if (r_state == FULL && (w_haz0 || (w_haz1 && !w_pair))) begin
      w_interlock = 1'b1;
    end else if (r_state == FULL && w_pair) begin
      w_nxt_pc = i_fetch.pc_in;
      w_nxt_i0 = w_i0;
      w_nxt_v0 = 1'b1;
      w_set = set_mask(w_op0, w_rd0);
      w_interlock = 1'b1;
      w_nxt_state = SECOND;
    end else if (r_state == SECOND && w_haz1) begin
      w_interlock = 1'b1;
    end else if (r_state == SECOND) begin
      w_nxt_pc = i_fetch.pc_in;
      w_nxt_i1 = w_live1 ? w_i1 : NOP_INST;
      w_nxt_v1 = w_live1;
      w_set = set_mask(w_op1, w_rd1);
      w_nxt_state = FULL;
    end else begin
      w_nxt_pc = (w_live0 || w_live1) ? i_fetch.pc_in : r_pc;
      w_nxt_i0 = w_live0 ? w_i0 : NOP_INST;
      w_nxt_v0 = w_live0;
      w_nxt_i1 = w_live1 ? w_i1 : NOP_INST;
      w_nxt_v1 = w_live1;
      w_set = set_mask(w_op0, w_rd0) | set_mask(w_op1, w_rd1);
    end
  end
  // state and issue register stage toward exec
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= FULL;
      r_pc <= '0;
      r_i0 <= NOP_INST;
      r_v0 <= 1'b0;
      r_i1 <= NOP_INST;
      r_v1 <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pc <= w_nxt_pc;
      r_i0 <= w_nxt_i0;
      r_v0 <= w_nxt_v0;
      r_i1 <= w_nxt_i1;
      r_v1 <= w_nxt_v1;
    end
  end
  assign i_fetch.interlock = w_interlock & rstn;
  assign o_issue_pc = r_pc;
  assign o_slot0_inst = r_i0;
  assign o_slot0_valid = r_v0;
  assign o_slot1_inst = r_i1;
  assign o_slot1_valid = r_v1;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: per-cycle vector table with an expected-output queue for decode_issue
module tb_decode_issue;
  import decode_issue_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i0;
    logic        v0;
    logic [31:0] i1;
    logic        v1;
  } out_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [5:0]  wb0;
    logic [5:0]  wb1;
    logic [5:0]  f;
  } vec_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        exec_stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb0_valid = 1'b0;
  logic        wb1_valid = 1'b0;
  logic [4:0]  wb0_rd = '0;
  logic [4:0]  wb1_rd = '0;
  logic [31:0] issue_pc, slot0_inst, slot1_inst;
  logic        slot0_valid, slot1_valid;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[$];
  out_t        expq[$];
  out_t        last;
  decode_issue_if fi();
  decode_issue dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_fetch      (fi),
    .i_exec_stall (exec_stall),
    .i_flush      (flush),
    .i_wb0_valid  (wb0_valid),
    .i_wb0_rd     (wb0_rd),
    .i_wb1_valid  (wb1_valid),
    .i_wb1_rd     (wb1_rd),
    .o_issue_pc   (issue_pc),
    .o_slot0_inst (slot0_inst),
    .o_slot0_valid(slot0_valid),
    .o_slot1_inst (slot1_inst),
    .o_slot1_valid(slot1_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(opcode_t op, int rd, int rs1, int rs2);
    return {op, rd[4:0], rs1[4:0], rs2[4:0], 11'b0};
  endfunction
  function automatic logic [5:0] W(int r);
    return {1'b1, r[4:0]};
  endfunction
  // f = {stall, flush, interlock, hold, ev0, ev1}
  task automatic add(logic [31:0] pc, logic [31:0] b0, logic [31:0] b1, logic [5:0] wb0, logic [5:0] wb1, logic [5:0] f);
    vec_t v;
    v.pc = pc;
    v.b0 = b0;
    v.b1 = b1;
    v.wb0 = wb0;
    v.wb1 = wb1;
    v.f = f;
    vecs.push_back(v);
  endtask
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic cmp_out(string name);
    out_t a;
    a = {issue_pc, slot0_inst, slot0_valid, slot1_inst, slot1_valid};
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%h required=queued-expectation", name, a);
    end else chk(name, a, expq.pop_front());
  endtask
  initial begin
    vec_t v;
    out_t e;
    add(32'h10, ins(Add,3,1,2), ins(Sub,4,5,6), 6'h0, 6'h0, 6'b00_0_0_11);
    add(32'h20, ins(Add,3,1,2), ins(Add,7,3,3), 6'h0, 6'h0, 6'b00_1_0_10);
    add(32'h20, ins(Add,3,1,2), ins(Add,7,3,3), 6'h0, 6'h0, 6'b00_0_0_01);
    add(32'h30, ins(Load,8,1,0), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'h40, ins(Add,9,8,1), 32'h0, 6'h0, 6'h0, 6'b00_1_0_00);
    add(32'h40, ins(Add,9,8,1), 32'h0, 6'h0, 6'h0, 6'b00_1_0_00);
    add(32'h40, ins(Add,9,8,1), 32'h0, W(8), 6'h0, 6'b00_0_0_10);
    add(32'h50, ins(Add,2,8,8), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'h60, ins(Load,8,1,0), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'h70, ins(Add,3,1,2), ins(Sub,5,3,4), 6'h0, 6'h0, 6'b00_1_0_10);
    add(32'h70, ins(Add,3,1,2), ins(Sub,5,3,4), 6'h0, 6'h0, 6'b01_0_0_00);
    add(32'h80, ins(Add,3,1,2), ins(Sub,5,3,4), 6'h0, 6'h0, 6'b00_1_0_10);
    add(32'h80, ins(Add,3,1,2), ins(Sub,5,3,4), 6'h0, 6'h0, 6'b00_0_0_01);
    add(32'h90, ins(Add,10,8,1), 32'h0, 6'h0, 6'h0, 6'b00_1_0_00);
    add(32'h90, ins(Add,10,8,1), 32'h0, 6'h0, W(8), 6'b00_0_0_10);
    for (int k = 0; k < 3; k++) add(32'hA0, ins(Load,11,1,2), 32'h0, 6'h0, 6'h0, 6'b10_1_1_00);
    add(32'hB0, ins(Add,12,11,1), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'hC0, ins(Load,5,1,2), 32'h0, W(5), 6'h0, 6'b00_0_0_10);
    add(32'hD0, ins(Add,6,5,1), 32'h0, 6'h0, 6'h0, 6'b00_1_0_00);
    add(32'hD0, ins(Add,6,5,1), 32'h0, W(0), W(0), 6'b00_1_0_00);
    add(32'hD0, ins(Add,6,5,1), 32'h0, 6'h0, W(5), 6'b00_0_0_10);
    add(32'hE0, ins(Load,0,1,2), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'hF0, ins(Add,1,0,0), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'h100, ins(Load,13,1,2), ins(Store,0,3,4), 6'h0, 6'h0, 6'b00_1_0_10);
    add(32'h100, ins(Load,13,1,2), ins(Store,0,3,4), 6'h0, 6'h0, 6'b00_0_0_01);
    add(32'h110, ins(Beq,0,1,2), ins(Beq,0,3,4), 6'h0, 6'h0, 6'b00_1_0_10);
    add(32'h110, ins(Beq,0,1,2), ins(Beq,0,3,4), 6'h0, 6'h0, 6'b00_0_0_01);
    add(32'h120, ins(Add,14,1,2), ins(Add,15,14,13), 6'h0, 6'h0, 6'b00_1_0_10);
    add(32'h120, ins(Add,14,1,2), ins(Add,15,14,13), 6'h0, 6'h0, 6'b00_1_0_00);
    add(32'h120, ins(Add,14,1,2), ins(Add,15,14,13), W(13), 6'h0, 6'b00_0_0_01);
    add(32'h130, ins(Mul,16,1,2), 32'h0, 6'h0, 6'h0, 6'b00_0_0_10);
    add(32'h140, ins(Add,17,1,2), ins(Sub,18,16,1), 6'h0, 6'h0, 6'b00_1_0_00);
    add(32'h140, ins(Add,17,1,2), ins(Sub,18,16,1), 6'h0, W(16), 6'b00_0_0_11);
    add(32'h150, 32'h0, 32'h0, 6'h0, 6'h0, 6'b00_0_0_00);
    fi.pc_in = 32'h5;
    fi.bundle_in = {ins(Add,3,1,2), ins(Add,4,3,3)};
    exec_stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_interlock", fi.interlock, 1'b0);
    last = {32'h0, NOP_INST, 1'b0, NOP_INST, 1'b0};
    chk("rst_out", {issue_pc, slot0_inst, slot0_valid, slot1_inst, slot1_valid}, last);
    rstn = 1'b1;
    exec_stall = 1'b0;
    fi.pc_in = '0;
    fi.bundle_in = '0;
    expq.push_back(last);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      cmp_out($sformatf("out_before_v%0d", k));
      v = vecs[k];
      fi.pc_in = v.pc;
      fi.bundle_in = {v.b0, v.b1};
      exec_stall = v.f[5];
      flush = v.f[4];
      wb0_valid = v.wb0[5];
      wb0_rd = v.wb0[4:0];
      wb1_valid = v.wb1[5];
      wb1_rd = v.wb1[4:0];
      #1;
      chk($sformatf("interlock_v%0d", k), fi.interlock, v.f[3]);
      e = v.f[2] ? last : {v.pc, v.f[1] ? v.b0 : NOP_INST, v.f[1], v.f[0] ? v.b1 : NOP_INST, v.f[0]};
      if (!v.f[2] && !v.f[1] && !v.f[0]) e.pc = last.pc;
      last = e;
      expq.push_back(e);
    end
    @(negedge clk);
    cmp_out("out_final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
